// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns field-level MIPS requests (op enum + register,
// shamt, immediate and target fields) into 32-bit instruction words and
// streams {address, word} pairs to instruction memory through a small
// output FIFO with a valid/ready handshake on both sides.
// Optional feature macro: ENC_ILLEGAL_TRAP_EN (trap ops >= 27 instead of
// emitting a NOP word).
module mips_instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_wren,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       count,
    output logic              illegal
);
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_D);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB   = 5'd1,  OP_SLT  = 5'd2,  OP_SLTU  = 5'd3,
        OP_AND  = 5'd4,  OP_OR    = 5'd5,  OP_NOR  = 5'd6,  OP_XOR   = 5'd7,
        OP_SLL  = 5'd8,  OP_SLLV  = 5'd9,  OP_SRA  = 5'd10, OP_SRAV  = 5'd11,
        OP_SRL  = 5'd12, OP_SRLV  = 5'd13, OP_ADDI = 5'd14, OP_ANDI  = 5'd15,
        OP_SLTI = 5'd16, OP_SLTIU = 5'd17, OP_ORI  = 5'd18, OP_XORI  = 5'd19,
        OP_BGTZ = 5'd20, OP_BLEZ  = 5'd21, OP_BNE  = 5'd22, OP_LW    = 5'd23,
        OP_SW   = 5'd24, OP_BEQ   = 5'd25, OP_J    = 5'd26
    } op_e;

    // Builds the instruction word: R-type for ops 0..13, I-type for 14..25,
    // J/JAL for 26 (rd=31 selects JAL), all-zero NOP for anything else.
    function automatic logic [31:0] encode(
        input logic [4:0]  op_i,
        input logic [4:0]  rs_i,
        input logic [4:0]  rt_i,
        input logic [4:0]  rd_i,
        input logic [4:0]  shamt_i,
        input logic [15:0] imm_i,
        input logic [25:0] target_i
    );
        logic [5:0]  code;
        logic        shift_imm;
        logic [31:0] word;
        code      = 6'h00;
        shift_imm = 1'b0;
        word      = 32'h0;
        case (op_e'(op_i))
            OP_ADD:   code = 6'h20;
            OP_SUB:   code = 6'h22;
            OP_SLT:   code = 6'h2A;
            OP_SLTU:  code = 6'h2B;
            OP_AND:   code = 6'h24;
            OP_OR:    code = 6'h25;
            OP_NOR:   code = 6'h27;
            OP_XOR:   code = 6'h26;
            OP_SLL:   begin code = 6'h00; shift_imm = 1'b1; end
            OP_SLLV:  code = 6'h04;
            OP_SRA:   begin code = 6'h03; shift_imm = 1'b1; end
            OP_SRAV:  code = 6'h07;
            OP_SRL:   begin code = 6'h02; shift_imm = 1'b1; end
            OP_SRLV:  code = 6'h06;
            OP_ADDI:  code = 6'h08;
            OP_ANDI:  code = 6'h0C;
            OP_SLTI:  code = 6'h0A;
            OP_SLTIU: code = 6'h0B;
            OP_ORI:   code = 6'h0D;
            OP_XORI:  code = 6'h0E;
            OP_BGTZ:  code = 6'h07;
            OP_BLEZ:  code = 6'h06;
            OP_BNE:   code = 6'h05;
            OP_LW:    code = 6'h23;
            OP_SW:    code = 6'h2B;
            OP_BEQ:   code = 6'h04;
            OP_J:     code = (rd_i == 5'd31) ? 6'h03 : 6'h02;
            default:  code = 6'h00;
        endcase
        if (op_i <= 5'd13) begin
            // Immediate shifts carry shamt and ignore rs; every other R-type zeroes shamt.
            word = {6'h00, shift_imm ? 5'd0 : rs_i, rt_i, rd_i,
                    shift_imm ? shamt_i : 5'd0, code};
        end else if (op_i <= 5'd25) begin
            word = {code, rs_i,
                    (op_i == OP_BGTZ || op_i == OP_BLEZ) ? 5'd0 : rt_i, imm_i};
        end else if (op_i == OP_J) begin
            word = {code, target_i};
        end
        return word;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_ctr_q, addr_ctr_d;
    logic [15:0]         count_q, count_d;
    logic                illegal_q, illegal_d;
    logic                done_q, done_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [31:0]         last_data_q, last_data_d;
    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_D];
    logic [31:0]         fifo_data_q [FIFO_D];

    logic        accept, push, pop, trap;
    logic [31:0] enc_word;

`ifdef ENC_ILLEGAL_TRAP_EN
    assign trap = (op >= 5'd27);
`else
    assign trap = 1'b0;
`endif

    // Handshake decode; in_ready depends on registered state only.
    assign in_ready  = (state_q == S_RUN) && (cnt_q < FULL_CNT);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !trap;
    assign imem_wren = (cnt_q != '0);
    assign pop       = imem_wren && out_ready;
    assign enc_word  = encode(op, rs, rt, rd, shamt, imm, target);

    assign imem_addr = imem_wren ? fifo_addr_q[head_q] : last_addr_q;
    assign imem_data = imem_wren ? fifo_data_q[head_q] : last_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign count     = count_q;
    assign illegal   = illegal_q;

    // Next-state, address/count bookkeeping and FIFO pointer updates.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        addr_ctr_d  = addr_ctr_q;
        count_d     = count_q;
        illegal_d   = illegal_q;
        done_d      = 1'b0;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    addr_ctr_d = base_addr;
                    count_d    = 16'd0;
                    illegal_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (accept && in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept && trap) illegal_d = 1'b1;

        if (push) begin
            tail_d     = tail_q + PTR_W'(1);
            addr_ctr_d = addr_ctr_q + ADDR_W'(4);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end

        if (pop) begin
            head_d      = head_q + PTR_W'(1);
            last_addr_d = fifo_addr_q[head_q];
            last_data_d = fifo_data_q[head_q];
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= S_IDLE;
            addr_ctr_q  <= '0;
            count_q     <= '0;
            illegal_q   <= 1'b0;
            done_q      <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_ctr_q  <= addr_ctr_d;
            count_q     <= count_d;
            illegal_q   <= illegal_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    // FIFO storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; cnt_q and head_q decide validity, so stale entries are never shown.
        if (push) begin
            fifo_addr_q[tail_q] <= addr_ctr_q;
            fifo_data_q[tail_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed encodings, back-pressure,
// drain/done timing with address wrap, illegal op handling and mid-run reset.
// Expected writes are queued at accept time and compared as imem pops them.
`timescale 1ns/1ps
module tb_mips_instr_encoder;
    localparam int ADDR_W = 32;
    localparam int FIFO_D = 2;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last, out_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [4:0]        op, rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              in_ready, imem_wren, busy, done, illegal;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [15:0]       count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb [$];
    wr_t         mon_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr = 32'h0;

    logic [5:0] r_funct [0:13] = '{6'h20, 6'h22, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h27,
                                   6'h26, 6'h00, 6'h04, 6'h03, 6'h07, 6'h02, 6'h06};
    logic [5:0] i_opc   [0:11] = '{6'h08, 6'h0C, 6'h0A, 6'h0B, 6'h0D, 6'h0E,
                                   6'h07, 6'h06, 6'h05, 6'h23, 6'h2B, 6'h04};

    mips_instr_encoder #(.ADDR_W(ADDR_W), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .imem_wren(imem_wren), .out_ready(out_ready), .imem_addr(imem_addr),
        .imem_data(imem_data), .busy(busy), .done(done), .count(count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder built from opcode/funct tables.
    function automatic logic [31:0] model(input int o, input logic [4:0] s, t, d, sh,
                                          input logic [15:0] im, input logic [25:0] tg);
        bit shift_k;
        shift_k = (o == 8) || (o == 10) || (o == 12);
        if (o < 14) return {6'h00, shift_k ? 5'd0 : s, t, d, shift_k ? sh : 5'd0, r_funct[o]};
        if (o < 26) return {i_opc[o-14], s, (o == 20 || o == 21) ? 5'd0 : t, im};
        if (o == 26) return {(d == 5'd31) ? 6'h03 : 6'h02, tg};
        return 32'h0;
    endfunction

    // Scoreboard: every imem pop is compared with the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && imem_wren === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                         imem_addr, imem_data);
            end else begin
                mon_exp = sb.pop_front();
                if (imem_addr !== mon_exp.addr || imem_data !== mon_exp.data) begin
                    n_fail++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offers one request for up to budget cycles; queues the expected write on accept.
    task automatic send(input logic [4:0] o, s, t, d, sh, input logic [15:0] im,
                        input logic [25:0] tg, input logic last, input logic [31:0] w,
                        input bit wr, input int budget, output bit ok);
        op = o; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
        in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_ready) begin
                if (wr) begin
                    sb.push_back({exp_addr, w});
                    exp_addr = exp_addr + 32'd4;
                end
                ok = 1'b1;
                break;
            end
        end
        sync();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic req(input logic [4:0] o, s, t, d, sh, input logic [15:0] im,
                       input logic [25:0] tg, input logic last, input logic [31:0] w, input bit wr);
        bit ok;
        send(o, s, t, d, sh, im, tg, last, w, wr, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: op=%0d in_ready=0 for 20 cycles, required accept", o);
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1; base_addr = b;
        sync();
        start = 1'b0;
        exp_addr = b;
        n_checks++;
        if (busy !== 1'b1 || count !== 16'd0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL start_state: got busy=%b count=%0d illegal=%b, required 1/0/0",
                     busy, count, illegal);
        end
    endtask

    task automatic wait_done();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_wait: got found=%b busy=%b, required done pulse with busy=0", found, busy);
        end
        sync();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, imem_wren, busy, done, illegal} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/wren/busy/done/ill=%b, required 00000",
                     {in_ready, imem_wren, busy, done, illegal});
        end
        n_checks++;
        if (imem_addr !== 32'h0 || imem_data !== 32'h0 || count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: got addr=%h data=%h count=%0d, required 0/0/0",
                     imem_addr, imem_data, count);
        end
        sync();
    endtask

    task automatic test_encode_basic();
        do_start(32'h100);
        out_ready = 1'b1;
        req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00221820, 1'b1);
        @(negedge clk);
        n_checks++;
        if (imem_wren !== 1'b1 || imem_addr !== 32'h100 || imem_data !== 32'h00221820) begin
            n_fail++;
            $display("FAIL add_latency: got wren=%b addr=%h data=%h, required 1 00000100 00221820",
                     imem_wren, imem_addr, imem_data);
        end
        sync();
        req(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0, 32'h2022FFFF, 1'b1);
        req(5'd23, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0, 32'h8CA40008, 1'b1);
        req(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b0, 32'h08000040, 1'b1);
        req(5'd8,  5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 32'h00031100, 1'b1);
        req(5'd0,  5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 1'b0, 32'h00221820, 1'b1);
        repeat (3) sync();
        n_checks++;
        if (count !== 16'd6 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_count: got count=%0d pending=%0d, required 6/0", count, sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [4];
        logic [31:0] first_addr;
        bit ok;
        int n_acc;
        n_acc = 0;
        w[0] = model(1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
        w[1] = model(5, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0);
        w[2] = model(6, 5'd10, 5'd11, 5'd12, 5'd0, 16'h0, 26'h0);
        w[3] = model(18, 5'd13, 5'd14, 5'd0, 5'd0, 16'h1234, 26'h0);
        first_addr = exp_addr;
        out_ready = 1'b0;
        send(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, w[0], 1'b1, 3, ok); n_acc += int'(ok);
        send(5'd5, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1'b0, w[1], 1'b1, 3, ok); n_acc += int'(ok);
        @(negedge clk);
        n_checks++;
        if (imem_data !== w[0] || imem_addr !== first_addr) begin
            n_fail++;
            $display("FAIL hold_early: got addr=%h data=%h, required %h %h", imem_addr, imem_data, first_addr, w[0]);
        end
        sync();
        send(5'd6, 5'd10, 5'd11, 5'd12, 5'd0, 16'h0, 26'h0, 1'b0, w[2], 1'b1, 3, ok); n_acc += int'(ok);
        send(5'd18, 5'd13, 5'd14, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0, w[3], 1'b1, 3, ok); n_acc += int'(ok);
        @(negedge clk);
        n_checks++;
        if (n_acc != 2 || in_ready !== 1'b0 || imem_wren !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall: got accepted=%0d in_ready=%b wren=%b, required 2/0/1", n_acc, in_ready, imem_wren);
        end
        n_checks++;
        if (imem_data !== w[0] || imem_addr !== first_addr) begin
            n_fail++;
            $display("FAIL hold_late: got addr=%h data=%h, required %h %h", imem_addr, imem_data, first_addr, w[0]);
        end
        sync();
        out_ready = 1'b1;
        repeat (4) sync();
        req(5'd6, 5'd10, 5'd11, 5'd12, 5'd0, 16'h0, 26'h0, 1'b0, w[2], 1'b1);
        req(5'd18, 5'd13, 5'd14, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, w[3], 1'b1);
        wait_done();
    endtask

    task automatic test_drain_wrap();
        logic [31:0] w2;
        do_start(32'hFFFF_FFFC);
        out_ready = 1'b1;
        w2 = model(25, 5'd3, 5'd9, 5'd0, 5'd0, 16'h8001, 26'h0);
        req(5'd7,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, model(7, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0), 1'b1);
        req(5'd18, 5'd2, 5'd6, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b0, model(18, 5'd2, 5'd6, 5'd0, 5'd0, 16'hBEEF, 26'h0), 1'b1);
        req(5'd25, 5'd3, 5'd9, 5'd0, 5'd0, 16'h8001, 26'h0, 1'b1, w2, 1'b1);
        @(negedge clk);
        n_checks++;
        if (imem_wren !== 1'b1 || imem_addr !== 32'h4 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_last: got wren=%b addr=%h busy=%b done=%b, required 1 00000004 1 0",
                     imem_wren, imem_addr, busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (imem_wren !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || imem_addr !== 32'h4 || imem_data !== w2) begin
            n_fail++;
            $display("FAIL drain_hold: got wren=%b busy=%b done=%b addr=%h data=%h, required 0 1 0 00000004 %h",
                     imem_wren, busy, done, imem_addr, imem_data, w2);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 16'd3) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b count=%0d, required 1 0 3", done, busy, count);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got done=%b, required 0", done);
        end
        sync();
    endtask

    task automatic test_illegal();
        do_start(32'h200);
        out_ready = 1'b1;
`ifdef ENC_ILLEGAL_TRAP_EN
        req(5'd30, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (illegal !== 1'b1 || imem_wren !== 1'b0 || count !== 16'd0) begin
            n_fail++;
            $display("FAIL trap: got illegal=%b wren=%b count=%0d, required 1 0 0", illegal, imem_wren, count);
        end
        sync();
        wait_done();
        n_checks++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_sticky: got illegal=%b, required 1", illegal);
        end
        do_start(32'h300);
        req(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00210820, 1'b1);
        wait_done();
`else
        req(5'd30, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (imem_wren !== 1'b1 || imem_data !== 32'h0 || imem_addr !== 32'h200 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_word: got wren=%b addr=%h data=%h illegal=%b, required 1 00000200 00000000 0",
                     imem_wren, imem_addr, imem_data, illegal);
        end
        sync();
        wait_done();
`endif
    endtask

    task automatic test_sweep();
        logic [4:0]  s, t, d, sh;
        logic [15:0] im;
        logic [25:0] tg;
        do_start(32'h1000);
        for (int k = 0; k < 27; k++) begin
            s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); sh = 5'($urandom);
            im = 16'($urandom); tg = 26'($urandom);
            out_ready = (k % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            req(5'(k), s, t, d, sh, im, tg, 1'b0, model(k, s, t, d, sh, im, tg), 1'b1);
        end
        out_ready = 1'b1;
        tg = 26'h2ABCDEF;
        req(5'd26, 5'd0, 5'd0, 5'd31, 5'd0, 16'h0, tg, 1'b1, model(26, 5'd0, 5'd0, 5'd31, 5'd0, 16'h0, tg), 1'b1);
        wait_done();
        n_checks++;
        if (sb.size() != 0 || count !== 16'd28) begin
            n_fail++;
            $display("FAIL sweep_end: got pending=%0d count=%0d, required 0/28", sb.size(), count);
        end
    endtask

    task automatic test_reset_mid();
        do_start(32'h40);
        out_ready = 1'b0;
        req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00221820, 1'b1);
        req(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00221822, 1'b1);
        reset = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if ({in_ready, imem_wren, busy, done, illegal} !== 5'b0 || count !== 16'd0 ||
            imem_addr !== 32'h0 || imem_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got flags=%b count=%0d addr=%h data=%h, required 00000 0 0 0",
                     {in_ready, imem_wren, busy, done, illegal}, count, imem_addr, imem_data);
        end
        sync();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) sync();
        n_checks++;
        if (busy !== 1'b0 || imem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got busy=%b wren=%b, required 0 0", busy, imem_wren);
        end
    endtask

    initial begin
        test_reset();
        test_encode_basic();
        test_backpressure();
        test_drain_wrap();
        test_illegal();
        test_sweep();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d pending writes, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
